// File: rtl/ir_loader_pkg.sv
// Shared types and sizing helpers for the serial IR RAM loader.
package ir_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Frame-level states: sync, length, payload words, checksum, abort.
  typedef enum logic [2:0] {
    F_IDLE,
    F_LEN_H,
    F_LEN_L,
    F_DATA_H,
    F_DATA_L,
    F_CSUM,
    F_ERR
  } frame_state_e;

  // Bit-level receiver states.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Clock cycles per serial bit, integer-truncated.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Width of a counter that must reach max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ir_loader_if.sv
// IR RAM write port plus loader status, shared by loader, RAM and processor.
interface ir_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] ir_m_data;
  logic [ADDR_W-1:0] ir_m_addr;
  logic              ir_m_wren;
  logic              loading;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  modport master (
    output ir_m_data, ir_m_addr, ir_m_wren, loading, done, error, word_count
  );

  modport slave (
    input ir_m_data, ir_m_addr, ir_m_wren, loading, done, error, word_count
  );
endinterface

// File: rtl/ir_loader_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection,
// framing-error report with re-arm only after the line returns high.
module uart_rx
  import ir_loader_pkg::*;
#(
  parameter int DIV = 520
)(
  input  logic       clock,
  input  logic       n_reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int HALF = (DIV >= 2) ? DIV / 2 : 1;
  localparam int CW   = cnt_w(DIV);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_prev;
  rx_state_e     state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick_half, tick_full;

  assign rx_s      = sync_q[1];
  assign tick_half = (cnt == CW'(HALF - 1));
  assign tick_full = (cnt == CW'(DIV - 1));
  assign rx_byte   = shreg;

  // Synchronize rxd; reset to idle-high so reset release is not a start edge.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      rx_prev <= rx_s;
    end
  end

  // Bit FSM state register.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= RX_IDLE;
    else          state <= nxt;
  end

  // Bit FSM next state.
  always_comb begin
    nxt = state;
    case (state)
      RX_IDLE:      if (rx_prev && !rx_s) nxt = RX_START;
      RX_START:     if (tick_half) nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (tick_full && bit_idx == 3'd7) nxt = RX_STOP;
      RX_STOP:      if (tick_full) nxt = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) nxt = RX_IDLE;
      default:      nxt = RX_IDLE;
    endcase
  end

  // Baud counter, LSB-first shift register and one-cycle result pulses.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_START: cnt <= tick_half ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (tick_full) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_full) begin
            cnt <= '0;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ir_loader.sv
// Serial program loader: parses A5/LEN/words/CSUM frames from uart_rx and
// writes words sequentially into IR RAM from address 0.
module ir_loader
  import ir_loader_pkg::*;
#(
  parameter int CLK_HZ       = 60_000_000,
  parameter int BAUD         = 115_200,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT_BITS = 20
)(
  input  logic       clock,
  input  logic       n_reset,
  input  logic       rxd,
  ir_loader_if.master ir
);

  localparam int          DIV       = calc_div(CLK_HZ, BAUD);
  localparam int          TMO_CYC   = TIMEOUT_BITS * DIV;
  localparam int          TW        = cnt_w(TMO_CYC);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  logic        byte_valid, frame_err;
  logic [7:0]  rx_byte;

  frame_state_e      state, nxt;
  logic [7:0]        len_h_q, hi_q, xor_q;
  logic [15:0]       len_q, len_full;
  logic [ADDR_W-1:0] addr_q, waddr_q;
  logic [ADDR_W:0]   wc_q;
  logic [DATA_W-1:0] data_q;
  logic              wren_q, loading_q, done_q, error_q;
  logic [TW-1:0]     tmo_q;
  logic              timeout, in_frame, abort, last_word, is_sync;

  uart_rx #(.DIV(DIV)) u_rx (
    .clock      (clock),
    .n_reset    (n_reset),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  assign len_full  = {len_h_q, rx_byte};
  assign last_word = ((32'(wc_q) + 32'd1) == 32'(len_q));
  assign timeout   = (tmo_q == TW'(TMO_CYC - 1));
  assign in_frame  = state inside {F_LEN_H, F_LEN_L, F_DATA_H, F_DATA_L, F_CSUM};
  // A byte arriving on the timeout cycle still counts; framing errors never coincide with bytes.
  assign abort     = in_frame && (frame_err || (timeout && !byte_valid));
  assign is_sync   = byte_valid && (rx_byte == SYNC_BYTE);

  // Frame FSM state register.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= F_IDLE;
    else          state <= nxt;
  end

  // Frame FSM next state; aborts override everything inside a frame.
  always_comb begin
    nxt = state;
    case (state)
      F_IDLE:   if (is_sync) nxt = F_LEN_H;
      F_LEN_H:  if (byte_valid) nxt = F_LEN_L;
      F_LEN_L: begin
        if (byte_valid) begin
          if ({16'd0, len_full} > MAX_WORDS) nxt = F_ERR;
          else if (len_full == 16'd0)        nxt = F_CSUM;
          else                               nxt = F_DATA_H;
        end
      end
      F_DATA_H: if (byte_valid) nxt = F_DATA_L;
      F_DATA_L: if (byte_valid) nxt = last_word ? F_CSUM : F_DATA_H;
      F_CSUM:   if (byte_valid) nxt = F_IDLE;
      F_ERR:    nxt = F_IDLE;
      default:  nxt = F_IDLE;
    endcase
    if (abort) nxt = F_ERR;
  end

  // Inter-byte idle counter; only meaningful while inside a frame.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)                       tmo_q <= '0;
    else if (state == F_IDLE || byte_valid) tmo_q <= '0;
    else if (!timeout)                  tmo_q <= tmo_q + 1'b1;
  end

  // Datapath: length, checksum, address/count, registered RAM write port, status.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      len_h_q   <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      xor_q     <= '0;
      addr_q    <= '0;
      waddr_q   <= '0;
      wc_q      <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      case (state)
        F_IDLE: begin
          if (is_sync) begin
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wc_q      <= '0;
            loading_q <= 1'b1;
            addr_q    <= '0;
            xor_q     <= '0;
          end
        end
        F_LEN_H: if (byte_valid) len_h_q <= rx_byte;
        F_LEN_L: if (byte_valid) len_q   <= len_full;
        F_DATA_H: begin
          if (byte_valid) begin
            hi_q  <= rx_byte;
            xor_q <= xor_q ^ rx_byte;
          end
        end
        F_DATA_L: begin
          if (byte_valid) begin
            wren_q  <= 1'b1;
            waddr_q <= addr_q;
            data_q  <= DATA_W'({hi_q, rx_byte});
            addr_q  <= addr_q + 1'b1;
            wc_q    <= wc_q + 1'b1;
            xor_q   <= xor_q ^ rx_byte;
          end
        end
        F_CSUM: begin
          if (byte_valid) begin
            done_q    <= (rx_byte == xor_q);
            error_q   <= (rx_byte != xor_q);
            loading_q <= 1'b0;
          end
        end
        F_ERR: begin
          error_q   <= 1'b1;
          loading_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ir.ir_m_data  = data_q;
  assign ir.ir_m_addr  = waddr_q;
  assign ir.ir_m_wren  = wren_q;
  assign ir.loading    = loading_q;
  assign ir.done       = done_q;
  assign ir.error      = error_q;
  assign ir.word_count = wc_q;

endmodule

// File: tb/tb_ir_loader.sv
// Scoreboard bench: expected RAM writes and end-of-frame status are queued as
// frames are sent; a negedge monitor pops and compares as the DUT produces them.
module tb_ir_loader;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int TBITS  = 20;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic            done;
    logic            error;
    logic [ADDR_W:0] wc;
  } st_t;

  logic clock = 1'b0;
  logic n_reset;
  logic rxd;

  int checks = 0;
  int errors = 0;
  wr_t wr_q[$];
  st_t st_q[$];
  logic prev_load = 1'b0;

  ir_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ir ();

  ir_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_BITS(TBITS)
  ) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .rxd     (rxd),
    .ir      (ir)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rxd = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clock);
    end
    rxd = stop;
    repeat (DIV) @(negedge clock);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clock);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic exp_wr(input int a, input int d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = DATA_W'(d);
    wr_q.push_back(w);
  endtask

  task automatic exp_st(input logic d, input logic e, input int wc);
    st_t s;
    s.done  = d;
    s.error = e;
    s.wc    = (ADDR_W+1)'(wc);
    st_q.push_back(s);
  endtask

  // Bounded wait for every queued expectation to be consumed.
  task automatic drain(input string name);
    int n = 0;
    while ((wr_q.size() != 0 || st_q.size() != 0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (wr_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL %s: pending writes %0d status %0d, required 0 0", name, wr_q.size(), st_q.size());
      wr_q.delete();
      st_q.delete();
    end
  endtask

  // Monitor: every write strobe cycle and every loading fall is an output event.
  always @(negedge clock) begin
    if (!n_reset) begin
      prev_load = 1'b0;
    end else begin
      if (ir.ir_m_wren) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, required none", ir.ir_m_addr, ir.ir_m_data);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (ir.ir_m_addr !== w.addr || ir.ir_m_data !== w.data) begin
            errors++;
            $display("FAIL wr: got addr %0h data %0h, required addr %0h data %0h",
                     ir.ir_m_addr, ir.ir_m_data, w.addr, w.data);
          end
        end
      end
      if (prev_load && !ir.loading) begin
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL st_unexpected: got done %0b error %0b wc %0d", ir.done, ir.error, ir.word_count);
        end else begin
          st_t s;
          s = st_q.pop_front();
          if (ir.done !== s.done || ir.error !== s.error || ir.word_count !== s.wc) begin
            errors++;
            $display("FAIL st: got done %0b error %0b wc %0d, required done %0b error %0b wc %0d",
                     ir.done, ir.error, ir.word_count, s.done, s.error, s.wc);
          end
        end
      end
      prev_load = ir.loading;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(ir.ir_m_data), 0);
    chk({tag, "_addr"},  32'(ir.ir_m_addr), 0);
    chk({tag, "_wren"},  32'(ir.ir_m_wren), 0);
    chk({tag, "_load"},  32'(ir.loading), 0);
    chk({tag, "_done"},  32'(ir.done), 0);
    chk({tag, "_error"}, 32'(ir.error), 0);
    chk({tag, "_wc"},    32'(ir.word_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0;
    rxd     = 1'b1;
    repeat (5) @(negedge clock);
    chk_all_zero("reset");
    n_reset = 1'b1;
    repeat (4 * DIV) @(negedge clock);

    // Test 1: good frame, loading must be up after the sync byte.
    exp_wr(0, 16'h1234);
    exp_wr(1, 16'hABCD);
    exp_st(1'b1, 1'b0, 2);
    send_byte(8'hA5);
    chk("t1_loading", 32'(ir.loading), 1);
    send_bytes('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40});
    drain("t1_drain");

    // Test 2: bad checksum, writes still happen.
    exp_wr(0, 16'h1234);
    exp_wr(1, 16'hABCD);
    exp_st(1'b0, 1'b1, 2);
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
    drain("t2_drain");

    // Test 3: noise before sync is ignored.
    send_bytes('{8'h00, 8'hFF, 8'h5A});
    chk("t3_noise_idle", 32'(ir.loading), 0);
    chk("t3_noise_error_kept", 32'(ir.error), 1);
    exp_wr(0, 16'h1234);
    exp_wr(1, 16'hABCD);
    exp_st(1'b1, 1'b0, 2);
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40});
    drain("t3_drain");

    // Test 4: length 0x1001 exceeds 4096 words.
    exp_st(1'b0, 1'b1, 0);
    send_bytes('{8'hA5, 8'h10, 8'h01});
    drain("t4_drain");

    // Test 5a: short low glitch is not a byte; sticky error proves no resync.
    rxd = 1'b0;
    repeat (DIV / 4) @(negedge clock);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clock);
    chk("t5a_loading", 32'(ir.loading), 0);
    chk("t5a_error_kept", 32'(ir.error), 1);

    // Test 5b: framing error while waiting for a high byte.
    exp_st(1'b0, 1'b1, 0);
    send_bytes('{8'hA5, 8'h00, 8'h01});
    send_byte(8'hBE, 1'b0);
    drain("t5b_drain");

    // Test 5c: 25 bit-times of silence mid-frame.
    exp_st(1'b0, 1'b1, 0);
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'hBE});
    repeat (25 * DIV) @(negedge clock);
    drain("t5c_drain");

    // Test 6: reset mid-frame, then a clean single-word frame.
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12});
    chk("t6_loading_pre", 32'(ir.loading), 1);
    n_reset = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    repeat (3) @(negedge clock);
    n_reset = 1'b1;
    repeat (2 * DIV) @(negedge clock);
    exp_wr(0, 16'hBEEF);
    exp_st(1'b1, 1'b0, 1);
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51});
    drain("t6_drain");
    chk("t6_addr_final", 32'(ir.ir_m_addr), 0);
    chk("t6_data_final", 32'(ir.ir_m_data), 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
